// File: rtl/rom_burst_reader.sv
// rom_burst_reader: burst address sequencer for a synchronous ROM.
// A start request walks `length` consecutive (wrapping) addresses from
// base_addr. Each returned byte goes into a small skid FIFO whose head is
// registered, so the consumer sees a valid/ready stream without losing or
// duplicating bytes. Issue is credit-limited so the FIFO can never overflow.
module rom_burst_reader #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 8,
  parameter int ROM_LAT = 1,
  parameter int FIFO_D  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  // Occupancy counter must hold 0..FIFO_D; pointers index 0..FIFO_D-1.
  localparam int CNT_W = $clog2(FIFO_D + 1);
  localparam int PTR_W = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
  localparam logic [CNT_W:0]    DEPTH_C = (CNT_W + 1)'(FIFO_D);
  localparam logic [PTR_W-1:0]  LAST_PTR_C = PTR_W'(FIFO_D - 1);
  localparam logic [CNT_W-1:0]  ONE_C = CNT_W'(1);
  localparam logic [ADDR_W:0]   LEN_ONE_C = (ADDR_W + 1)'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Circular pointer advance that also works for non-power-of-two depths.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    logic [PTR_W-1:0] r;
    if (p == LAST_PTR_C) begin
      r = {PTR_W{1'b0}};
    end else begin
      r = p + PTR_W'(1);
    end
    return r;
  endfunction

  // Control state
  state_t              state_r;
  state_t              state_s;
  logic [ADDR_W-1:0]   addr_cnt_r;
  logic [ADDR_W:0]     remain_r;
  logic [ROM_LAT-1:0]  pipe_r;

  // Registered outputs
  logic [ADDR_W-1:0]   rom_addr_r;
  logic [DATA_W-1:0]   out_data_r;
  logic                out_valid_r;
  logic                busy_r;
  logic                done_r;

  // Skid FIFO storage (out_data_r mirrors the entry at rd_ptr_r)
  logic [DATA_W-1:0]   mem_r [FIFO_D];
  logic [PTR_W-1:0]    wr_ptr_r;
  logic [PTR_W-1:0]    rd_ptr_r;
  logic [CNT_W-1:0]    count_r;

  // Combinational helpers
  logic                issue_s;
  logic                load_s;
  logic [ADDR_W-1:0]   issue_addr_s;
  logic                push_s;
  logic                pop_s;
  logic [CNT_W-1:0]    in_flight_s;
  logic                credit_ok_s;
  logic [CNT_W-1:0]    count_next_s;
  logic [PTR_W-1:0]    rd_ptr_next_s;
  logic [DATA_W-1:0]   head_next_s;

  assign rom_addr  = rom_addr_r;
  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign done      = done_r;

  // Credit accounting: words already buffered plus words still inside the ROM.
  always_comb begin
    in_flight_s = {CNT_W{1'b0}};
    for (int i = 0; i < ROM_LAT; i++) begin
      in_flight_s = in_flight_s + CNT_W'(pipe_r[i]);
    end
    credit_ok_s = (({1'b0, count_r} + {1'b0, in_flight_s}) < DEPTH_C);
    push_s      = pipe_r[ROM_LAT-1];
    pop_s       = out_valid_r & out_ready;
  end

  // Next-state logic and issue decision; the first address goes out with start.
  always_comb begin
    state_s = state_r;
    issue_s = 1'b0;
    load_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          if (length == {(ADDR_W + 1){1'b0}}) begin
            state_s = ST_DONE;
          end else begin
            load_s  = 1'b1;
            issue_s = 1'b1;
            if (length == LEN_ONE_C) begin
              state_s = ST_DRAIN;
            end else begin
              state_s = ST_ISSUE;
            end
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (credit_ok_s) begin
          issue_s = 1'b1;
          if (remain_r == LEN_ONE_C) begin
            state_s = ST_DRAIN;
          end else begin
            state_s = ST_ISSUE;
          end
        end else begin
          state_s = ST_ISSUE;
        end
      end
      ST_DRAIN: begin
        if ((count_r == ONE_C) && pop_s && (in_flight_s == {CNT_W{1'b0}})) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    if (load_s) begin
      issue_addr_s = base_addr;
    end else begin
      issue_addr_s = addr_cnt_r;
    end
  end

  // FIFO bookkeeping: next occupancy and the value the registered head takes.
  always_comb begin
    count_next_s  = count_r;
    rd_ptr_next_s = ptr_inc(rd_ptr_r);
    head_next_s   = out_data_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + ONE_C;
      2'b01:   count_next_s = count_r - ONE_C;
      default: count_next_s = count_r;
    endcase
    if (pop_s && (count_r > ONE_C)) begin
      head_next_s = mem_r[rd_ptr_next_s];
    end else if (push_s && ((count_r == {CNT_W{1'b0}}) || (pop_s && (count_r == ONE_C)))) begin
      head_next_s = rom_data;
    end else begin
      head_next_s = out_data_r;
    end
  end

  // State register plus registered busy/done derived from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s != ST_IDLE);
      done_r  <= (state_s == ST_DONE);
    end
  end

  // Address walker: ROM address, next address, remaining words, in-flight pipe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rom_addr_r <= {ADDR_W{1'b0}};
      addr_cnt_r <= {ADDR_W{1'b0}};
      remain_r   <= {(ADDR_W + 1){1'b0}};
      pipe_r     <= {ROM_LAT{1'b0}};
    end else begin
      pipe_r[0] <= issue_s;
      for (int i = 1; i < ROM_LAT; i++) begin
        pipe_r[i] <= pipe_r[i-1];
      end
      if (issue_s) begin
        rom_addr_r <= issue_addr_s;
        addr_cnt_r <= issue_addr_s + ADDR_W'(1);
        if (load_s) begin
          remain_r <= length - LEN_ONE_C;
        end else begin
          remain_r <= remain_r - LEN_ONE_C;
        end
      end else begin
        rom_addr_r <= rom_addr_r;
        addr_cnt_r <= addr_cnt_r;
        remain_r   <= remain_r;
      end
    end
  end

  // Skid FIFO: storage, pointers, occupancy and the registered stream head.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_D; i++) begin
        mem_r[i] <= {DATA_W{1'b0}};
      end
      wr_ptr_r    <= {PTR_W{1'b0}};
      rd_ptr_r    <= {PTR_W{1'b0}};
      count_r     <= {CNT_W{1'b0}};
      out_data_r  <= {DATA_W{1'b0}};
      out_valid_r <= 1'b0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= rom_data;
        wr_ptr_r        <= ptr_inc(wr_ptr_r);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_next_s;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      count_r     <= count_next_s;
      out_data_r  <= head_next_s;
      out_valid_r <= (count_next_s != {CNT_W{1'b0}});
    end
  end

endmodule

// File: tb/tb_rom_burst_reader.sv
// Directed bench for rom_burst_reader with a scoreboard of expected ROM bytes.
module tb_rom_burst_reader;

  logic        clk;
  logic        rst;
  logic        start;
  logic [9:0]  base_addr;
  logic [10:0] length;
  logic [9:0]  rom_addr;
  logic [7:0]  rom_data;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int done_cnt  = 0;
  int acc_cnt   = 0;
  logic [7:0] exp_q[$];
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'd0;

  rom_burst_reader dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
    .rom_addr(rom_addr), .rom_data(rom_data), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done)
  );

  // ROM contents as a fixed function of address.
  function automatic logic [7:0] rom_val(input int a);
    int m;
    m = a & 1023;
    return 8'(((m * 13) + (m >> 4)) ^ 32'h3C);
  endfunction

  // ROM read path with one cycle of latency relative to the issue edge.
  assign rom_data = rom_val(int'(rom_addr));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic burst(input int b, input int len, input bit push_exp);
    start     = 1'b1;
    base_addr = 10'(b);
    length    = 11'(len);
    if (push_exp) begin
      for (int i = 0; i < len; i++) exp_q.push_back(rom_val(b + i));
    end
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
  endtask

  // Stream monitor: scoreboard compare on accept, stability while stalled, done count.
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_data", 32'(out_data), 32'(prev_data));
      end
      if (done === 1'b1) done_cnt++;
      if (out_valid && out_ready) begin
        acc_cnt++;
        if (exp_q.size() == 0) chk("extra_word", 32'(out_valid), 32'd0);
        else chk("stream", 32'(out_data), 32'(exp_q.pop_front()));
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d", total_cnt);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int d0;
    rst = 1'b1; start = 1'b0; base_addr = 10'd0; length = 11'd0; out_ready = 1'b1;
    #1 rst = 1'b0;
    #2;
    chk("rst_addr", 32'(rom_addr), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    #9 rst = 1'b1;
    step();

    // T1: short burst, first word two cycles after start
    burst(700, 3, 1'b1);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_valid0", 32'(out_valid), 32'd0);
    chk("t1_addr", 32'(rom_addr), 32'd700);
    step();
    chk("t1_first_valid", 32'(out_valid), 32'd1);
    chk("t1_first_data", 32'(out_data), 32'(rom_val(700)));
    step();
    chk("t1_second_data", 32'(out_data), 32'(rom_val(701)));
    step();
    chk("t1_third_data", 32'(out_data), 32'(rom_val(702)));
    step();
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_valid_end", 32'(out_valid), 32'd0);
    step();
    chk("t1_done_clear", 32'(done), 32'd0);
    chk("t1_idle", 32'(busy), 32'd0);
    chk("t1_sb_empty", 32'(exp_q.size()), 32'd0);

    // T2: address wrap
    burst(1022, 4, 1'b1);
    chk("t2_a0", 32'(rom_addr), 32'd1022);
    step(); chk("t2_a1", 32'(rom_addr), 32'd1023);
    step(); chk("t2_a2", 32'(rom_addr), 32'd0);
    step(); chk("t2_a3", 32'(rom_addr), 32'd1);
    wait_done("t2", 20);
    step();
    chk("t2_idle", 32'(busy), 32'd0);
    chk("t2_sb_empty", 32'(exp_q.size()), 32'd0);

    // T3: back-pressure, issue stalls once credits are exhausted
    out_ready = 1'b0;
    burst(800, 8, 1'b1);
    repeat (8) step();
    chk("t3_stall_addr", 32'(rom_addr), 32'd803);
    chk("t3_full_valid", 32'(out_valid), 32'd1);
    chk("t3_head", 32'(out_data), 32'(rom_val(800)));
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      out_ready = (n % 4 == 0);
      step();
      n++;
    end
    chk("t3_done", 32'(done), 32'd1);
    out_ready = 1'b1;
    step();
    chk("t3_idle", 32'(busy), 32'd0);
    chk("t3_sb_empty", 32'(exp_q.size()), 32'd0);

    // T4: zero length, ignored starts
    burst(300, 0, 1'b1);
    chk("t4_done", 32'(done), 32'd1);
    chk("t4_busy", 32'(busy), 32'd1);
    chk("t4_valid", 32'(out_valid), 32'd0);
    burst(900, 5, 1'b0);
    chk("t4_ignored_busy", 32'(busy), 32'd0);
    chk("t4_addr_hold", 32'(rom_addr), 32'd807);
    step();
    chk("t4_no_valid", 32'(out_valid), 32'd0);
    chk("t4_still_idle", 32'(busy), 32'd0);
    burst(100, 6, 1'b1);
    step();
    burst(900, 3, 1'b0);
    wait_done("t4", 40);
    step();
    chk("t4_last_addr", 32'(rom_addr), 32'd105);
    chk("t4_sb_empty", 32'(exp_q.size()), 32'd0);

    // T5: reset mid-burst
    acc_cnt = 0;
    burst(900, 16, 1'b1);
    n = 0;
    while (acc_cnt < 5 && n < 50) begin
      step();
      n++;
    end
    chk("t5_words", 32'(acc_cnt), 32'd5);
    rst = 1'b0;
    exp_q.delete();
    #1;
    chk("t5_rst_addr", 32'(rom_addr), 32'd0);
    chk("t5_rst_valid", 32'(out_valid), 32'd0);
    chk("t5_rst_data", 32'(out_data), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_done", 32'(done), 32'd0);
    d0 = done_cnt;
    step();
    step();
    #2 rst = 1'b1;
    repeat (3) step();
    chk("t5_post_busy", 32'(busy), 32'd0);
    chk("t5_no_done", 32'(done_cnt - d0), 32'd0);
    burst(0, 2, 1'b1);
    wait_done("t5", 20);
    step();
    chk("t5_sb_empty", 32'(exp_q.size()), 32'd0);

    // T6: full-ROM burst with wrap
    d0 = done_cnt;
    burst(512, 1024, 1'b1);
    wait_done("t6", 1200);
    step();
    chk("t6_done_once", 32'(done_cnt - d0), 32'd1);
    chk("t6_last_addr", 32'(rom_addr), 32'd511);
    chk("t6_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
